mem_port_arbiter: RTL

- Arbitrates the core's single-port data RAM between two requesters: the load unit (reads) and the store retire buffer (writes).
- Issues at most one memory operation per cycle, so MemRead and MemWrite are never both asserted.
- Registers load data with the requester's tag, and holds it until the consumer accepts it.
- Sits between the LSU/retire logic and the main memory block.

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port data RAM shared by the load unit and the store retire buffer.
// Stores normally win. A load that has been denied too often is forced ahead of the stores.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [DATA_W-1:0] resp_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LOAD,
        GNT_STORE
    } grant_e;

    grant_e           grant;
    logic             ld_ok;
    logic [CNT_W-1:0] starve_cnt;

    // The response slot holds one entry. It can drain and refill in the same cycle.
    assign ld_ok = ld_valid && (!resp_valid || resp_ready);

    // NOTE: every signal is given a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant        = GNT_NONE;
        ld_ready     = 1'b0;
        st_ready     = 1'b0;
        mem_valid    = 1'b0;
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        mem_addr     = '0;
        mem_wr_data  = '0;

        if (!reset) begin
            if (ld_ok && (!st_valid || starve_cnt >= CNT_MAX)) begin
                grant = GNT_LOAD;
            end else if (st_valid) begin
                grant = GNT_STORE;
            end
        end

        case (grant)
            GNT_LOAD: begin
                ld_ready    = 1'b1;
                mem_valid   = 1'b1;
                mem_MemRead = 1'b1;
                mem_addr    = ld_addr;
            end
            GNT_STORE: begin
                st_ready     = 1'b1;
                mem_valid    = 1'b1;
                mem_MemWrite = 1'b1;
                mem_addr     = st_addr;
                mem_wr_data  = st_data;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!ld_valid || grant == GNT_LOAD) begin
            starve_cnt <= '0;
        end else if (ld_ok && grant == GNT_STORE && starve_cnt < CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // The response slot is overwritten only by a load granted in this cycle. It drains when the consumer accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else if (grant == GNT_LOAD) begin
            resp_valid <= 1'b1;
            resp_tag   <= ld_tag;
            resp_data  <= mem_rd_data;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    a_one_strobe: assert property (@(posedge clk) !(mem_MemRead && mem_MemWrite));
    a_one_ready:  assert property (@(posedge clk) !(ld_ready && st_ready));
    a_resp_hold:  assert property (@(posedge clk) disable iff (reset)
        (resp_valid && !resp_ready) |=> ($stable(resp_tag) && $stable(resp_data)));

endmodule
